// File: rtl/uart_stream.sv
// Full-duplex 8N1 UART that bridges a serial line to a valid/ready byte stream.
// Both directions share one clock and a fixed integer bit-period divider.
module uart_stream #(
  parameter int CLK_DIV = 104
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic       o_uart_tx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_err_frame,
  output logic       o_err_overrun
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  rx_state_t     rx_state_q, rx_state_d;
  logic          rx_meta_q, rx_meta_d, rxs_q, rxs_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          err_frame_q, err_frame_d, err_overrun_q, err_overrun_d;

  tx_state_t     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          tx_line_q, tx_line_d, tx_ready_q, tx_ready_d;

  // Stream handshake (both directions): a byte moves on any rising edge where
  // valid && ready are both high; the producer holds valid and data until then.

  // Counter loads N-1 and the sample happens on the edge that sees it at zero,
  // i.e. exactly N clocks after the load.
  always_comb begin
    rx_meta_d     = i_uart_rx;
    rxs_d         = rx_meta_q;
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q - CW'(1);
    rx_bit_d      = rx_bit_q;
    rx_sh_d       = rx_sh_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q && !i_rx_ready;
    err_frame_d   = 1'b0;
    err_overrun_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (!rxs_q) begin
        rx_state_d = RX_START;
        rx_cnt_d   = HALF_M1;
      end
      RX_START: if (rx_cnt_q == '0) begin
        if (rxs_q) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_state_d = RX_DATA;
          rx_cnt_d   = FULL_M1;
          rx_bit_d   = 3'd0;
        end
      end
      RX_DATA: if (rx_cnt_q == '0) begin
        rx_sh_d  = {rxs_q, rx_sh_q[7:1]};
        rx_cnt_d = FULL_M1;
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == '0) begin
        if (rxs_q) begin
          // Leave mid-stop-bit so a back-to-back start edge is not missed.
          rx_state_d = RX_IDLE;
          if (!rx_valid_q || i_rx_ready) begin
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
          end else begin
            err_overrun_d = 1'b1;
          end
        end else begin
          err_frame_d = 1'b1;
          rx_state_d  = RX_BREAK;
        end
      end
      RX_BREAK: if (rxs_q) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q - CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_line_d  = tx_line_q;
    case (tx_state_q)
      TX_IDLE: if (i_tx_valid) begin
        tx_sh_d    = i_tx_data;
        tx_state_d = TX_START;
        tx_line_d  = 1'b0;
        tx_cnt_d   = FULL_M1;
      end
      TX_START: if (tx_cnt_q == '0) begin
        tx_line_d  = tx_sh_q[0];
        tx_sh_d    = {1'b0, tx_sh_q[7:1]};
        tx_bit_d   = 3'd0;
        tx_cnt_d   = FULL_M1;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_cnt_q == '0) begin
        tx_cnt_d = FULL_M1;
        if (tx_bit_q == 3'd7) begin
          tx_line_d  = 1'b1;
          tx_state_d = TX_STOP;
        end else begin
          tx_line_d = tx_sh_q[0];
          tx_sh_d   = {1'b0, tx_sh_q[7:1]};
          tx_bit_d  = tx_bit_q + 3'd1;
        end
      end
      TX_STOP: if (tx_cnt_q == '0) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
    tx_ready_d = (tx_state_d == TX_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_q     <= 1'b1;
      rxs_q         <= 1'b1;
      rx_state_q    <= RX_IDLE;
      rx_cnt_q      <= '0;
      rx_bit_q      <= 3'd0;
      rx_sh_q       <= 8'd0;
      rx_data_q     <= 8'd0;
      rx_valid_q    <= 1'b0;
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
      tx_state_q    <= TX_IDLE;
      tx_cnt_q      <= '0;
      tx_bit_q      <= 3'd0;
      tx_sh_q       <= 8'd0;
      tx_line_q     <= 1'b1;
      tx_ready_q    <= 1'b1;
    end else begin
      rx_meta_q     <= rx_meta_d;
      rxs_q         <= rxs_d;
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_sh_q       <= rx_sh_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      err_frame_q   <= err_frame_d;
      err_overrun_q <= err_overrun_d;
      tx_state_q    <= tx_state_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_bit_q      <= tx_bit_d;
      tx_sh_q       <= tx_sh_d;
      tx_line_q     <= tx_line_d;
      tx_ready_q    <= tx_ready_d;
    end
  end

  assign o_uart_tx     = tx_line_q;
  assign o_tx_ready    = tx_ready_q;
  assign o_rx_data     = rx_data_q;
  assign o_rx_valid    = rx_valid_q;
  assign o_err_frame   = err_frame_q;
  assign o_err_overrun = err_overrun_q;
endmodule
